// File: rtl/cache_fill_ctrl.sv
// Block fill sequencer: issues BLOCK_WORDS word reads, steers returning data into the I- or D-cache.
// Latency: issue starts the cycle after a miss is taken; fill_done one cycle after the last returned word.
// Backpressure: none; memory is pipelined with fixed latency. Word order: FILL_CRITICAL_WORD_FIRST_EN.
module cache_fill_ctrl #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_data,
    output logic        fill_we,
    output logic        fill_sel,
    output logic [2:0]  fill_word,
    output logic [15:0] fill_data,
    output logic        fill_tag_we,
    output logic        fill_done,
    output logic        busy
);

    localparam int            IW   = $clog2(BLOCK_WORDS);
    localparam logic [IW-1:0] LAST = IW'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        nextState;
    logic [IW-1:0] issueCnt;
    logic [IW-1:0] recvCnt;
    logic [15:0]   missAddr;
    logic          fillSelQ;
    logic [IW-1:0] issueIdx;
    logic [IW-1:0] recvIdx;
    logic [15:0]   blockBase;
    logic          dataAccept;
    logic          recvLast;

    // Counters are IW bits wide, so the additions wrap modulo BLOCK_WORDS for free.
`ifdef FILL_CRITICAL_WORD_FIRST_EN
    logic [IW-1:0] missOff;
    assign missOff  = missAddr[IW:1];
    assign issueIdx = missOff + issueCnt;
    assign recvIdx  = missOff + recvCnt;
`else
    assign issueIdx = issueCnt;
    assign recvIdx  = recvCnt;
`endif

    // Base has the in-block byte offset cleared; OR-ing the index keeps the fill inside the block.
    assign blockBase  = missAddr & ~16'(2 * BLOCK_WORDS - 1);
    assign mem_addr   = blockBase | 16'({issueIdx, 1'b0});
    assign fill_word  = 3'(recvIdx);
    assign fill_data  = mem_data;
    assign fill_sel   = fillSelQ;
    assign dataAccept = mem_data_valid && (state == ISSUE || state == DRAIN);
    assign recvLast   = dataAccept && (recvCnt == LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; the last returned word ends the fill even while still issuing
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (d_miss || i_miss) nextState = ISSUE;
            ISSUE: begin
                if (recvLast)              nextState = DONE;
                else if (issueCnt == LAST) nextState = DRAIN;
            end
            DRAIN:   if (recvLast) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Strobes decoded from state; fill writes only accepted while a fill is in flight
    always_comb begin
        mem_en      = 1'b0;
        fill_we     = 1'b0;
        fill_tag_we = 1'b0;
        fill_done   = 1'b0;
        busy        = (state != IDLE);
        case (state)
            ISSUE: begin
                mem_en      = 1'b1;
                fill_we     = dataAccept;
                fill_tag_we = recvLast;
            end
            DRAIN: begin
                fill_we     = dataAccept;
                fill_tag_we = recvLast;
            end
            DONE:    fill_done = 1'b1;
            default: ;
        endcase
    end

    // Miss capture (D wins over I) and issue/receive counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            missAddr <= '0;
            fillSelQ <= 1'b0;
            issueCnt <= '0;
            recvCnt  <= '0;
        end else begin
            if (state == IDLE) begin
                issueCnt <= '0;
                recvCnt  <= '0;
                if (d_miss) begin
                    missAddr <= d_miss_addr;
                    fillSelQ <= 1'b1;
                end else if (i_miss) begin
                    missAddr <= i_miss_addr;
                    fillSelQ <= 1'b0;
                end
            end else begin
                if (state == ISSUE) issueCnt <= issueCnt + IW'(1);
                if (dataAccept)     recvCnt  <= recvCnt + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: directed scenarios plus random fills, scored against queued expectations.
// Memory responder returns data after a per-fill latency; data is a fixed function of the address.
// Word order expectation follows FILL_CRITICAL_WORD_FIRST_EN, same as the design build.
module tb_cache_fill_ctrl;

    localparam int BW = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_miss, d_miss;
    logic [15:0] i_miss_addr, d_miss_addr;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data;
    logic        fill_we, fill_sel, fill_tag_we, fill_done, busy;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;

    int checks = 0;
    int errors = 0;
    int lat = 4;
    int cyc = 0;
    int issTotal = 0;
    int doneCnt = 0;
    int runLen = 0;
    bit abortRun = 0;

    // expectations for issues and fill writes, in order
    logic [15:0] qIss[$];
    int          qWord[$];
    logic [15:0] qData[$];
    logic        qSel[$];
    logic        qLast[$];
    // memory pipeline
    int          dueQ[$];
    logic [15:0] adrQ[$];

    cache_fill_ctrl #(.BLOCK_WORDS(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_data_valid(mem_data_valid), .mem_data(mem_data),
        .fill_we(fill_we), .fill_sel(fill_sel), .fill_word(fill_word),
        .fill_data(fill_data), .fill_tag_we(fill_tag_we),
        .fill_done(fill_done), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memFn(input logic [15:0] a);
        return (a * 16'd37) ^ 16'hC3A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a block is 2*BW bytes; issue k fetches word (off+k)%BW (critical first) or k.
    task automatic pushFill(input logic sel, input logic [15:0] addr);
        int base, off, idx;
        base = int'(addr) - (int'(addr) % (2 * BW));
        off  = (int'(addr) % (2 * BW)) / 2;
        for (int k = 0; k < BW; k++) begin
`ifdef FILL_CRITICAL_WORD_FIRST_EN
            idx = (off + k) % BW;
`else
            idx = k;
`endif
            qIss.push_back(16'(base + 2 * idx));
            qWord.push_back(idx);
            qData.push_back(memFn(16'(base + 2 * idx)));
            qSel.push_back(sel);
            qLast.push_back(k == BW - 1);
        end
    endtask

    // Wait (bounded) for fill_done, check target, then requester drops its miss a cycle later
    task automatic waitDone(input logic sel, input string tag);
        int n = 0;
        while (fill_done !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_done_seen"}, 32'(n < 300), 1);
        chk({tag, "_done_sel"}, 32'(fill_sel), 32'(sel));
        @(posedge clk); #1;
        if (sel) d_miss = 1'b0; else i_miss = 1'b0;
        chk({tag, "_idle_after_done"}, 32'(busy), 0);
    endtask

    // Memory responder plus output monitor, both evaluated mid-cycle
    initial begin
        mem_data_valid = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_en === 1'b1) begin
                dueQ.push_back(cyc + lat);
                adrQ.push_back(mem_addr);
            end
            if (dueQ.size() > 0 && dueQ[0] == cyc) begin
                void'(dueQ.pop_front());
                mem_data_valid = 1'b1;
                mem_data = memFn(adrQ.pop_front());
            end else begin
                mem_data_valid = 1'b0;
                mem_data = 16'($urandom);
            end
            #1;
            if (mem_en === 1'b1) begin
                issTotal++;
                runLen++;
                if (qIss.size() == 0) chk("spurious_mem_en", 1, 0);
                else chk("mem_addr", 32'(mem_addr), 32'(qIss.pop_front()));
            end else if (runLen != 0) begin
                if (!abortRun) chk("issue_run_len", 32'(runLen), BW);
                runLen = 0;
                abortRun = 0;
            end
            if (fill_we === 1'b1) begin
                if (qWord.size() == 0) chk("spurious_fill_we", 1, 0);
                else begin
                    chk("fill_word", 32'(fill_word), 32'(qWord.pop_front()));
                    chk("fill_data", 32'(fill_data), 32'(qData.pop_front()));
                    chk("fill_sel", 32'(fill_sel), 32'(qSel.pop_front()));
                    chk("fill_tag_we", 32'(fill_tag_we), 32'(qLast.pop_front()));
                end
            end else if (fill_tag_we !== 1'b0) begin
                chk("tag_we_without_we", 32'(fill_tag_we), 0);
            end
            if (fill_done === 1'b1) doneCnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, s0;
        logic sel;
        logic [15:0] a, b;
        rst_n = 1'b0;
        i_miss = 1'b0; d_miss = 1'b0;
        i_miss_addr = '0; d_miss_addr = '0;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_fill_we", 32'(fill_we), 0);
        chk("rst_tag_we", 32'(fill_tag_we), 0);
        chk("rst_done", 32'(fill_done), 0);
        chk("rst_sel", 32'(fill_sel), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);

        // I miss at 0x1236, latency 4, pending at reset release: taken on the first edge
        @(posedge clk); #1;
        lat = 4;
        pushFill(1'b0, 16'h1236);
        i_miss_addr = 16'h1236; i_miss = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_edge_busy", 32'(busy), 1);
        waitDone(1'b0, "imiss");

        // D miss near top of memory: block stays at 0xFFF0..0xFFFE
        lat = 3;
        pushFill(1'b1, 16'hFFFA);
        d_miss_addr = 16'hFFFA; d_miss = 1'b1;
        waitDone(1'b1, "dtop");

        // Simultaneous misses: D first, one idle cycle, then I
        lat = 5;
        d0 = doneCnt;
        pushFill(1'b1, 16'h8000);
        pushFill(1'b0, 16'h0040);
        d_miss_addr = 16'h8000; i_miss_addr = 16'h0040;
        d_miss = 1'b1; i_miss = 1'b1;
        waitDone(1'b1, "both_d");
        @(posedge clk); #1;
        chk("both_i_taken", 32'(busy), 1);
        waitDone(1'b0, "both_i");
        chk("both_done_pulses", 32'(doneCnt - d0), 2);

        // Reset after the third issue of a D fill: abort, trailing data ignored
        lat = 4;
        d0 = doneCnt;
        s0 = issTotal;
        pushFill(1'b1, 16'h2A6C);
        d_miss_addr = 16'h2A6C; d_miss = 1'b1;
        for (int n = 0; n < 50 && issTotal - s0 < 3; n++) begin
            @(posedge clk); #1;
        end
        chk("abort_three_issued", 32'(issTotal - s0), 3);
        rst_n = 1'b0;
        d_miss = 1'b0;
        abortRun = 1;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_mem_en", 32'(mem_en), 0);
        chk("abort_fill_we", 32'(fill_we), 0);
        chk("abort_tag_we", 32'(fill_tag_we), 0);
        chk("abort_sel", 32'(fill_sel), 0);
        qIss.delete(); qWord.delete(); qData.delete(); qSel.delete(); qLast.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(doneCnt - d0), 0);
        chk("abort_idle", 32'(busy), 0);

        // Random fills, sometimes with both misses pending
        for (int t = 0; t < 8; t++) begin
            lat = $urandom_range(1, 6);
            a = 16'($urandom);
            b = 16'($urandom);
            sel = 1'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                pushFill(1'b1, a);
                pushFill(1'b0, b);
                d_miss_addr = a; i_miss_addr = b;
                d_miss = 1'b1; i_miss = 1'b1;
                waitDone(1'b1, "rnd_pair_d");
                waitDone(1'b0, "rnd_pair_i");
            end else begin
                pushFill(sel, a);
                if (sel) begin d_miss_addr = a; d_miss = 1'b1; end
                else     begin i_miss_addr = a; i_miss = 1'b1; end
                waitDone(sel, "rnd_single");
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        #1;
        chk("issues_left", 32'(qIss.size()), 0);
        chk("fills_left", 32'(qWord.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 Parameter BLOCK_WORDS, default 8: 16-bit words per cache block; power of 2, range 2..8.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_miss  input  1  I-cache miss request; held high until fill_done with fill_sel=0.
REQ-005 i_miss_addr  input  16  I-cache miss byte address; stable while i_miss high.
REQ-006 d_miss  input  1  D-cache miss request; held high until fill_done with fill_sel=1.
REQ-007 d_miss_addr  input  16  D-cache miss byte address; stable while d_miss high.
REQ-008 mem_en  output  1  main-memory read issue strobe, one word per cycle.
REQ-009 mem_addr  output  16  main-memory word byte-address for current issue.
REQ-010 mem_data_valid  input  1  main-memory read data valid; returns in issue order, fixed pipelined latency.
REQ-011 mem_data  input  16  main-memory read data.
REQ-012 fill_we  output  1  write one fill word into selected cache data array.
REQ-013 fill_sel  output  1  target cache: 0 = I-cache, 1 = D-cache; constant for a whole fill.
REQ-014 fill_word  output  3  word index within block for fill_we.
REQ-015 fill_data  output  16  fill word data (= mem_data, combinational pass-through).
REQ-016 fill_tag_we  output  1  write tag/valid for the block; asserted with the last fill_we.
REQ-017 fill_done  output  1  one-cycle completion pulse to the requester selected by fill_sel.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 States: IDLE, ISSUE, DRAIN, DONE; 2-bit encoding.
REQ-020 IDLE: if d_miss, latch d_miss_addr, fill_sel=1, go ISSUE; else if i_miss, latch i_miss_addr, fill_sel=0, go ISSUE; D has priority when both are high.
REQ-021 Block base = latched address with low log2(BLOCK_WORDS)+1 bits cleared.
REQ-022 ISSUE: mem_en=1 for exactly BLOCK_WORDS consecutive cycles; mem_addr = base + 2*word index (per REQ-035/036); issue counter increments each cycle; after last issue go DRAIN.
REQ-023 Receive counter counts mem_data_valid in ISSUE and DRAIN; each valid asserts fill_we with fill_word = index of the matching issue, same cycle.
REQ-024 On the BLOCK_WORDS-th valid, fill_tag_we=1 in the same cycle and go DONE next edge, whether in ISSUE or DRAIN.
REQ-025 mem_data_valid in IDLE or DONE is ignored; no fill_we.
REQ-026 DONE: fill_done=1 for one cycle, then IDLE; misses are not sampled in DONE.
REQ-027 Requester drops its miss the cycle after fill_done; a still-pending other miss is taken in the following IDLE cycle (back-to-back fills, 1 idle cycle between).
REQ-028 Address arithmetic is 16-bit, wraps modulo 2^16; block never crosses a block boundary.
REQ-029 Outputs mem_en, fill_we, fill_tag_we, fill_done are 0 outside the states defined above.

Reset
REQ-030 rst_n low: state=IDLE, counters=0, latched address=0, fill_sel=0, all strobes 0, busy=0, immediately (asynchronous).
REQ-031 Reset mid-fill aborts: no fill_tag_we, no fill_done; in-flight memory data after release is ignored in IDLE.
REQ-032 After rst_n rises, first miss is sampled on the first rising edge.

Configuration
REQ-033 Macro FILL_CRITICAL_WORD_FIRST_EN selects fill word order.
REQ-034 Index of issue k (k = 0..BLOCK_WORDS-1) is used for both mem_addr and fill_word.
REQ-035 Defined: index = (miss word offset + k) mod BLOCK_WORDS; the missed word is fetched first and the order wraps.
REQ-036 Undefined: index = k; sequential order 0..BLOCK_WORDS-1.

Verification
REQ-037 i_miss=1, addr 0x1236, latency 4, macro off -> mem_addr 0x1230..0x123E on 8 consecutive cycles; fill_word 0..7; fill_tag_we on 8th valid; fill_done, fill_sel=0.
REQ-038 Same stimulus, macro on -> mem_addr 0x1236,0x1238,...,0x123E,0x1230,0x1232,0x1234; fill_word 3,4,5,6,7,0,1,2.
REQ-039 i_miss and d_miss rise same cycle (d 0x8000, i 0x0040) -> D fill first (fill_sel=1), then I fill after 1 IDLE cycle; two fill_done pulses total.
REQ-040 rst_n low after 3rd issue -> busy=0, outputs 0 immediately; trailing mem_data_valid pulses produce no fill_we; no fill_done.
REQ-041 d_miss addr 0xFFFA -> base 0xFFF0, last mem_addr 0xFFFE; no wrap to 0x0000.
